// File: rtl/median_filter.sv
`default_nettype none
// ============================================================================
// Module      : median_filter
// Description : Streaming 3x3 median filter for 8-bit greyscale images stored
//               line-interleaved across three read BRAMs (row k in BRAM k%3).
//               One 32-bit word (4 pixels) is read from each BRAM per cycle,
//               and four median pixels plus an output word address are
//               produced per cycle.
// Ports       : clk        - single clock, rising edge
//               rst_n      - synchronous reset, active-HIGH (legacy name)
//               bypass     - (MEDIAN_BYPASS_EN only) pass centre-row pixels
//               word0..2   - read data from BRAM A/B/C
//               raddr_a..c - read addresses for BRAM A/B/C
//               pixel1..4  - column medians of the current word, pixel1 left
//               waddr      - output word address (wraps)
//               out_valid  - pixel1..4 / waddr valid this cycle
//               done       - sticky frame-complete flag
// Options     : define MEDIAN_BYPASS_EN to add the bypass input.
// Revision    : 1.0 - initial release
// ============================================================================
module median_filter #(
  parameter int MEM_DATA_WIDTH   = 32,
  parameter int PIXEL_DATA_WIDTH = 8,
  parameter int LUT_ADDR_WIDTH   = 14,
  parameter int MEM_ADDR_WIDTH   = 14,
  parameter int IMG_WIDTH        = 320,
  parameter int IMG_HEIGHT       = 320
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef MEDIAN_BYPASS_EN
  input  logic                        bypass,
`endif
  input  logic [MEM_DATA_WIDTH-1:0]   word0,
  input  logic [MEM_DATA_WIDTH-1:0]   word1,
  input  logic [MEM_DATA_WIDTH-1:0]   word2,
  output logic [LUT_ADDR_WIDTH-1:0]   raddr_a,
  output logic [LUT_ADDR_WIDTH-1:0]   raddr_b,
  output logic [LUT_ADDR_WIDTH-1:0]   raddr_c,
  output logic [PIXEL_DATA_WIDTH-1:0] pixel1,
  output logic [PIXEL_DATA_WIDTH-1:0] pixel2,
  output logic [PIXEL_DATA_WIDTH-1:0] pixel3,
  output logic [PIXEL_DATA_WIDTH-1:0] pixel4,
  output logic [MEM_ADDR_WIDTH-1:0]   waddr,
  output logic                        out_valid,
  output logic                        done
);

  localparam int P   = PIXEL_DATA_WIDTH;
  localparam int WPR = IMG_WIDTH / 4;
  localparam int WW  = $clog2(WPR + 1);
  localparam int RW  = $clog2(IMG_HEIGHT);
  localparam logic [LUT_ADDR_WIDTH-1:0] WPR_L = LUT_ADDR_WIDTH'(WPR);

  localparam logic [1:0] S_READ  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // ---------------------------------------------------------------- helpers
  function automatic logic [P-1:0] min2(input logic [P-1:0] a, input logic [P-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [P-1:0] max2(input logic [P-1:0] a, input logic [P-1:0] b);
    return (a < b) ? b : a;
  endfunction

  function automatic logic [P-1:0] med3(input logic [P-1:0] a, input logic [P-1:0] b,
                                        input logic [P-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  // ---------------------------------------------------------------- control
  logic [1:0]                state;
  logic [1:0]                state_next;
  logic                      issue_read;
  logic                      issue_shift;
  logic [WW-1:0]             word_cnt;
  logic [RW-1:0]             window_line_counter;
  logic [1:0]                oldest_bank;      // bank holding row r-1
  logic [LUT_ADDR_WIDTH-1:0] bank_base [3];    // base address of this row's line in each bank
  logic                      word_last;
  logic                      row_last;

  assign word_last = (word_cnt == WW'(WPR - 1));
  assign row_last  = (window_line_counter == RW'(IMG_HEIGHT - 2));

  always_ff @(posedge clk) begin
    if (rst_n) state <= S_READ;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_READ:  if (word_last) state_next = S_FLUSH;
      S_FLUSH: state_next = row_last ? S_DONE : S_READ;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_READ;
    endcase
  end

  always_comb begin
    issue_read  = (state == S_READ);
    issue_shift = (state == S_READ) || (state == S_FLUSH);
    done        = (state == S_DONE);
  end

  // Row/word counters and per-bank line bases. Moving to row r+1 replaces
  // row r-1 by row r+2 in the same bank, i.e. that bank's base steps by WPR.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      word_cnt            <= '0;
      window_line_counter <= RW'(1);
      oldest_bank         <= 2'd0;
      for (int b = 0; b < 3; b++) bank_base[b] <= '0;
    end else begin
      case (state)
        S_READ: word_cnt <= word_last ? '0 : word_cnt + WW'(1);
        S_FLUSH: begin
          if (!row_last) begin
            window_line_counter <= window_line_counter + RW'(1);
            for (int b = 0; b < 3; b++) begin
              if (oldest_bank == 2'(b)) bank_base[b] <= bank_base[b] + WPR_L;
            end
            oldest_bank <= (oldest_bank == 2'd2) ? 2'd0 : oldest_bank + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------- issue and data tags
  // Each cycle that shifts the window carries a tag naming the word entering
  // the "next" slot; the flush cycle uses index WPR (no real word).
  logic          iss_shift, dat_shift;
  logic [WW-1:0] iss_w, dat_w;
`ifdef MEDIAN_BYPASS_EN
  logic [1:0]    iss_ctr, dat_ctr, win_ctr;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      raddr_a   <= '0;
      raddr_b   <= '0;
      raddr_c   <= '0;
      iss_shift <= 1'b0;
      iss_w     <= '0;
      dat_shift <= 1'b0;
      dat_w     <= '0;
`ifdef MEDIAN_BYPASS_EN
      iss_ctr   <= 2'd0;
      dat_ctr   <= 2'd0;
`endif
    end else begin
      if (issue_read) begin
        raddr_a <= bank_base[0] + LUT_ADDR_WIDTH'(word_cnt);
        raddr_b <= bank_base[1] + LUT_ADDR_WIDTH'(word_cnt);
        raddr_c <= bank_base[2] + LUT_ADDR_WIDTH'(word_cnt);
      end
      iss_shift <= issue_shift;
      iss_w     <= issue_read ? word_cnt : WW'(WPR);
      dat_shift <= iss_shift;
      dat_w     <= iss_w;
`ifdef MEDIAN_BYPASS_EN
      // Centre row r lives in the bank after the one holding row r-1.
      iss_ctr   <= (oldest_bank == 2'd2) ? 2'd0 : oldest_bank + 2'd1;
      dat_ctr   <= iss_ctr;
`endif
    end
  end

  // ---------------------------------------------------------------- window
  logic [MEM_DATA_WIDTH-1:0] cur_word  [3];
  logic [MEM_DATA_WIDTH-1:0] next_word [3];
  logic [P-1:0]              prev_col  [3];   // rightmost pixel of previous word
  logic [WW-1:0]             win_w;           // index of word in "next"
  logic                      win_fire;
  logic [MEM_DATA_WIDTH-1:0] bank_word [3];

  assign bank_word[0] = word0;
  assign bank_word[1] = word1;
  assign bank_word[2] = word2;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int b = 0; b < 3; b++) begin
        cur_word[b]  <= '0;
        next_word[b] <= '0;
        prev_col[b]  <= '0;
      end
      win_w    <= '0;
      win_fire <= 1'b0;
`ifdef MEDIAN_BYPASS_EN
      win_ctr  <= 2'd0;
`endif
    end else begin
      win_fire <= dat_shift && (dat_w != '0);
      if (dat_shift) begin
        for (int b = 0; b < 3; b++) begin
          prev_col[b]  <= cur_word[b][P-1:0];
          cur_word[b]  <= next_word[b];
          next_word[b] <= bank_word[b];
        end
        win_w <= dat_w;
`ifdef MEDIAN_BYPASS_EN
        win_ctr <= dat_ctr;
`endif
      end
    end
  end

  // Six vertical triples: left neighbour, the 4 word columns, right neighbour.
  // Image edges clamp to the nearest in-image column.
  logic [P-1:0] col_pix [6][3];
  logic         at_left, at_right;

  assign at_left  = (win_w == WW'(1));
  assign at_right = (win_w == WW'(WPR));

  always_comb begin
    for (int b = 0; b < 3; b++) begin
      col_pix[0][b] = at_left  ? cur_word[b][MEM_DATA_WIDTH-1 -: P] : prev_col[b];
      col_pix[5][b] = at_right ? cur_word[b][P-1:0] : next_word[b][MEM_DATA_WIDTH-1 -: P];
      for (int i = 0; i < 4; i++) begin
        col_pix[i+1][b] = cur_word[b][MEM_DATA_WIDTH-1 - i*P -: P];
      end
    end
  end

  // --------------------------------------------- stage 1: sort each triple
  logic [P-1:0] tri_lo [6];
  logic [P-1:0] tri_mid[6];
  logic [P-1:0] tri_hi [6];

  for (genvar c = 0; c < 6; c++) begin : g_sort
    assign tri_lo[c]  = min2(min2(col_pix[c][0], col_pix[c][1]), col_pix[c][2]);
    assign tri_mid[c] = med3(col_pix[c][0], col_pix[c][1], col_pix[c][2]);
    assign tri_hi[c]  = max2(max2(col_pix[c][0], col_pix[c][1]), col_pix[c][2]);
  end

  logic [P-1:0] s1_lo [6];
  logic [P-1:0] s1_mid[6];
  logic [P-1:0] s1_hi [6];
  logic         s1_valid;
`ifdef MEDIAN_BYPASS_EN
  logic [P-1:0] s1_ctr [4];
  logic         s1_bypass;
  logic [MEM_DATA_WIDTH-1:0] ctr_word;

  always_comb begin
    case (win_ctr)
      2'd0:    ctr_word = cur_word[0];
      2'd1:    ctr_word = cur_word[1];
      default: ctr_word = cur_word[2];
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < 6; c++) begin
        s1_lo[c]  <= '0;
        s1_mid[c] <= '0;
        s1_hi[c]  <= '0;
      end
      s1_valid <= 1'b0;
`ifdef MEDIAN_BYPASS_EN
      for (int i = 0; i < 4; i++) s1_ctr[i] <= '0;
      s1_bypass <= 1'b0;
`endif
    end else begin
      for (int c = 0; c < 6; c++) begin
        s1_lo[c]  <= tri_lo[c];
        s1_mid[c] <= tri_mid[c];
        s1_hi[c]  <= tri_hi[c];
      end
      s1_valid <= win_fire;
`ifdef MEDIAN_BYPASS_EN
      for (int i = 0; i < 4; i++) s1_ctr[i] <= ctr_word[MEM_DATA_WIDTH-1 - i*P -: P];
      s1_bypass <= bypass;
`endif
    end
  end

  // ------------------------------------------- stage 2: median of 3x3
  // With each triple sorted, the median of nine is
  // med3(max of the lows, med of the mids, min of the highs).
  logic [P-1:0] sel_pix [4];

  for (genvar i = 0; i < 4; i++) begin : g_med
    logic [P-1:0] lo_max, mid_med, hi_min, med_pix;
    assign lo_max  = max2(max2(s1_lo[i], s1_lo[i+1]), s1_lo[i+2]);
    assign mid_med = med3(s1_mid[i], s1_mid[i+1], s1_mid[i+2]);
    assign hi_min  = min2(min2(s1_hi[i], s1_hi[i+1]), s1_hi[i+2]);
    assign med_pix = med3(lo_max, mid_med, hi_min);
`ifdef MEDIAN_BYPASS_EN
    assign sel_pix[i] = s1_bypass ? s1_ctr[i] : med_pix;
`else
    assign sel_pix[i] = med_pix;
`endif
  end

  logic [MEM_ADDR_WIDTH-1:0] addr_cnt;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pixel1    <= '0;
      pixel2    <= '0;
      pixel3    <= '0;
      pixel4    <= '0;
      waddr     <= '0;
      addr_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        pixel1   <= sel_pix[0];
        pixel2   <= sel_pix[1];
        pixel3   <= sel_pix[2];
        pixel4   <= sel_pix[3];
        // Outputs arrive strictly in row-major order, so a running count is
        // exactly (r-1)*WPR + w modulo the address width.
        waddr    <= addr_cnt;
        addr_cnt <= addr_cnt + MEM_ADDR_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_median_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_median_filter
// Description : Self-checking bench for median_filter. Frames are described
//               in a table, applied through BRAM models, and every output
//               word is compared against a brute-force 3x3 median model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_median_filter;

  localparam int MDW    = 32;
  localparam int PW     = 8;
  localparam int LAW    = 12;
  localparam int MAW    = 11;
  localparam int IW     = 128;
  localparam int IH     = 104;
  localparam int WPR    = IW / 4;
  localparam int NOUT   = (IH - 2) * WPR;
  localparam int BUDGET = 6000;

  localparam int K_CONST     = 0;
  localparam int K_IMPULSE   = 1;
  localparam int K_RAMP      = 2;
  localparam int K_EDGE      = 3;
  localparam int K_RANDOM    = 4;
  localparam int K_RANDSMALL = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
`ifdef MEDIAN_BYPASS_EN
  logic           bypass = 1'b0;
`endif
  logic [MDW-1:0] word0, word1, word2;
  logic [LAW-1:0] raddr_a, raddr_b, raddr_c;
  logic [PW-1:0]  pixel1, pixel2, pixel3, pixel4;
  logic [MAW-1:0] waddr;
  logic           out_valid, done;

  always #5 clk = ~clk;

  median_filter #(
    .MEM_DATA_WIDTH(MDW), .PIXEL_DATA_WIDTH(PW), .LUT_ADDR_WIDTH(LAW),
    .MEM_ADDR_WIDTH(MAW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MEDIAN_BYPASS_EN
    .bypass(bypass),
`endif
    .word0(word0), .word1(word1), .word2(word2),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .raddr_c(raddr_c),
    .pixel1(pixel1), .pixel2(pixel2), .pixel3(pixel3), .pixel4(pixel4),
    .waddr(waddr), .out_valid(out_valid), .done(done)
  );

  // Image and BRAM models (1-cycle read latency).
  logic [7:0]  img [IH][IW];
  logic [31:0] mem [3][4096];

  always @(posedge clk) begin
    word0 <= mem[0][raddr_a];
    word1 <= mem[1][raddr_b];
    word2 <= mem[2][raddr_c];
  end

  typedef struct packed {
    logic [31:0]    pix;
    logic [MAW-1:0] addr;
  } exp_t;

  typedef struct {
    int         kind;
    logic [7:0] val;
    bit         byp;
    int         exp_count;
    int         reset_at;
  } frame_t;

  exp_t        exp_q[$];
  frame_t      tests[$];
  logic [31:0] gw [NOUT];
  logic [MAW-1:0] last_waddr;
  int          checks = 0;
  int          fails  = 0;
  int          idx;

  task automatic fill_image(input int kind, input logic [7:0] val);
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        case (kind)
          K_CONST:     img[r][c] = val;
          K_IMPULSE:   img[r][c] = (r == 100 && c == 100) ? val : 8'h00;
          K_RAMP:      img[r][c] = 8'(r);
          K_EDGE:      img[r][c] = (c < 2) ? 8'hFF : 8'h00;
          K_RANDSMALL: img[r][c] = 8'($urandom_range(0, 3));
          default:     img[r][c] = 8'($urandom);
        endcase
      end
    end
    for (int k = 0; k < IH; k++) begin
      for (int w = 0; w < WPR; w++) begin
        mem[k % 3][(k / 3) * WPR + w] =
          {img[k][4*w], img[k][4*w+1], img[k][4*w+2], img[k][4*w+3]};
      end
    end
  endtask

  function automatic int px(input int r, input int c);
    int cc;
    cc = (c < 0) ? 0 : (c > IW - 1) ? IW - 1 : c;
    return int'(img[r][cc]);
  endfunction

  function automatic int median9(input int r, input int c);
    int v[9];
    int k, t;
    k = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        v[k] = px(r + dr, c + dc);
        k++;
      end
    for (int i = 1; i < 9; i++)
      for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
        t = v[j]; v[j] = v[j-1]; v[j-1] = t;
      end
    return v[4];
  endfunction

  task automatic build_expected(input bit byp);
    exp_t e;
    int   v;
    exp_q.delete();
    for (int r = 1; r <= IH - 2; r++) begin
      for (int w = 0; w < WPR; w++) begin
        for (int j = 0; j < 4; j++) begin
          v = byp ? px(r, 4*w + j) : median9(r, 4*w + j);
          e.pix[31 - 8*j -: 8] = 8'(v);
        end
        e.addr = MAW'((r - 1) * WPR + w);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({pixel1, pixel2, pixel3, pixel4} !== 32'h0 || waddr !== '0 || out_valid !== 1'b0 ||
        done !== 1'b0 || raddr_a !== '0 || raddr_b !== '0 || raddr_c !== '0) begin
      fails++;
      $display("FAIL %s: pix=%h waddr=%0d valid=%b done=%b raddr=%0d/%0d/%0d, required all zero",
               name, {pixel1, pixel2, pixel3, pixel4}, waddr, out_valid, done,
               raddr_a, raddr_b, raddr_c);
    end
  endtask

  task automatic run_frame(input int exp_count, input int reset_at);
    int          cyc, first_v, done_seen;
    bit          pulsed;
    logic [31:0] got;
    pulsed = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b0;
    idx = 0; cyc = 0; first_v = -1; done_seen = 0;
    while (done_seen < 8 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (first_v < 0) first_v = cyc;
        got = {pixel1, pixel2, pixel3, pixel4};
        last_waddr = waddr;
        if (idx < NOUT) gw[idx] = got;
        checks++;
        if (idx >= exp_q.size()) begin
          fails++;
          $display("FAIL extra_output #%0d: got pix=%h waddr=%0d, required no output", idx, got, waddr);
        end else if (got !== exp_q[idx].pix || waddr !== exp_q[idx].addr) begin
          fails++;
          $display("FAIL output #%0d: got pix=%h waddr=%0d, required pix=%h waddr=%0d",
                   idx, got, waddr, exp_q[idx].pix, exp_q[idx].addr);
        end
        idx++;
        if (!pulsed && idx == reset_at) begin
          pulsed = 1'b1;
          rst_n = 1'b1;
          @(negedge clk);
          check_zero("mid_frame_reset");
          rst_n = 1'b0;
          idx = 0; cyc = 0; first_v = -1;
        end
      end
      if (done) done_seen++;
    end
    checks++;
    if (cyc >= BUDGET) begin
      fails++;
      $display("FAIL frame_timeout: got %0d cycles without done, required done within %0d", cyc, BUDGET);
    end
    checks++;
    if (first_v != 6) begin
      fails++;
      $display("FAIL first_valid_latency: got cycle %0d, required cycle 6", first_v);
    end
    checks++;
    if (idx != exp_count) begin
      fails++;
      $display("FAIL valid_count: got %0d, required %0d", idx, exp_count);
    end
    checks++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL done_flag: got %b, required 1", done);
    end
  endtask

  initial begin
    frame_t t;
    tests.push_back('{K_CONST,     8'h55, 1'b0, NOUT, -1});
    tests.push_back('{K_IMPULSE,   8'hFF, 1'b0, NOUT, -1});
    tests.push_back('{K_RAMP,      8'h00, 1'b0, NOUT, -1});
    tests.push_back('{K_EDGE,      8'h00, 1'b0, NOUT, -1});
    tests.push_back('{K_RANDOM,    8'h00, 1'b0, NOUT, -1});
    tests.push_back('{K_RANDSMALL, 8'h00, 1'b0, NOUT, -1});
    tests.push_back('{K_RANDOM,    8'h00, 1'b0, NOUT, 49 * WPR + 10});
`ifdef MEDIAN_BYPASS_EN
    tests.push_back('{K_IMPULSE,   8'hFF, 1'b1, NOUT, -1});
    tests.push_back('{K_RANDOM,    8'h00, 1'b1, NOUT, -1});
`endif

    for (int n = 0; n < tests.size(); n++) begin
      t = tests[n];
      fill_image(t.kind, t.val);
      build_expected(t.byp);
`ifdef MEDIAN_BYPASS_EN
      bypass = t.byp;
`endif
      run_frame(t.exp_count, t.reset_at);

      // Hand-written corner checks on the captured outputs.
      if (t.kind == K_EDGE) begin
        checks++;
        if (gw[0][31:8] !== 24'hFFFF00) begin
          fails++;
          $display("FAIL edge_clamp_word0: got pixel1..3=%h, required ffff00", gw[0][31:8]);
        end
      end
      if (t.kind == K_RAMP) begin
        checks++;
        if (last_waddr !== MAW'(NOUT - 1)) begin
          fails++;
          $display("FAIL waddr_wrap_last: got %0d, required %0d", last_waddr, MAW'(NOUT - 1));
        end
      end
      if (t.kind == K_IMPULSE && t.byp) begin
        checks++;
        if (gw[99 * WPR + 25][31:24] !== 8'hFF) begin
          fails++;
          $display("FAIL bypass_impulse: got %h, required ff", gw[99 * WPR + 25][31:24]);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/median_filter.md
Name: median_filter

Overview:
- Streaming 3x3 median filter for 8-bit greyscale images held in three line-interleaved read BRAMs (image row k lives in BRAM k mod 3).
- Reads one 32-bit word (4 pixels) from each BRAM per cycle and emits 4 median pixels per cycle with an output word address.
- Sits between the input frame BRAMs and the output frame memory / capture logic.

Parameters:
- MEM_DATA_WIDTH, 32, BRAM word width; must equal 4*PIXEL_DATA_WIDTH
- PIXEL_DATA_WIDTH, 8, bits per pixel
- LUT_ADDR_WIDTH, 14, width of the input BRAM read addresses
- MEM_ADDR_WIDTH, 14, width of the output write address
- IMG_WIDTH, 320, pixels per row; multiple of 4; WPR = IMG_WIDTH/4 words per row
- IMG_HEIGHT, 320, rows; must be >= 3

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-high (legacy name kept; asserted = 1)
- word0  in  MEM_DATA_WIDTH  read data from BRAM A (rows k, k mod 3 = 0)
- word1  in  MEM_DATA_WIDTH  read data from BRAM B (k mod 3 = 1)
- word2  in  MEM_DATA_WIDTH  read data from BRAM C (k mod 3 = 2)
- raddr_a / raddr_b / raddr_c  out  LUT_ADDR_WIDTH  read addresses for BRAM A/B/C
- pixel1..pixel4  out  PIXEL_DATA_WIDTH  medians of the 4 columns of the current word; pixel1 = leftmost
- waddr  out  MEM_ADDR_WIDTH  output word address
- out_valid  out  1  pixel1..4/waddr valid this cycle
- done  out  1  sticky; frame complete

Behaviour:
- Memory layout: row k, word w at BRAM (k mod 3), address (k/3)*WPR + w. Word bits [31:24] = leftmost pixel, [7:0] = rightmost.
- BRAM read latency 1 cycle: data for an address presented at edge t is on wordN after edge t+1.
- Output rows r = 1..IMG_HEIGHT-2. Rows 0 and IMG_HEIGHT-1 are not produced. Internal window_line_counter holds r.
- For row r, each BRAM is addressed with whichever of rows r-1, r, r+1 it holds, at the same word w. Median is order-independent, so no row reordering is needed.
- Per row: WPR read cycles (w = 0..WPR-1), then 1 flush cycle with no read, then advance r. After the last row: done = 1, addresses hold, out_valid stays 0.
- Window: per row, a 3-word shift register (prev, cur, next). Neighbour columns come from the adjacent words.
- Column edges clamp: column -1 uses column 0, column IMG_WIDTH uses column IMG_WIDTH-1.
- Median: 9-input sorting network, unsigned compare, exact median of the 3x3 neighbourhood, pipelined in 2 register stages.
- Latency: out_valid for word w rises 4 cycles after the read address for word w+1 is issued (flush cycle stands in for w = WPR-1).
- waddr = ((r-1)*WPR + w) mod 2^MEM_ADDR_WIDTH; it wraps and does not saturate. Exactly (IMG_HEIGHT-2)*WPR valid outputs per frame, in row-major order.
- Reset (any cycle, including mid-frame): r = 1, w = 0, pipeline flushed, raddr_* = 0, pixel1..4 = 0, waddr = 0, out_valid = 0, done = 0. Frame restarts on the first cycle after release.
- No backpressure; the consumer must accept one word per valid cycle.

Optional Feature:
- Macro MEDIAN_BYPASS_EN.
- When defined: adds input port bypass (1 bit). When bypass = 1, pixel1..4 output the centre (row r) pixels through the same latency instead of the medians; addressing and valid timing are unchanged.
- When not defined: no bypass port, median only.

Test Plan:
- Constant image 0x55, 320x320 -> every valid output = 0x55; count of out_valid = 318*80 = 25440; done = 1 afterwards.
- All-zero image with single impulse 0xFF at (100,100) -> all outputs 0x00.
- Row ramp (pixel = row mod 256) -> output row r pixels all equal r; waddr sequence 0, 1, 2, ... wrapping 16383 -> 0.
- Image with 0xFF in columns 0 and 1 of every row, else 0x00 -> pixel1 and pixel2 of word 0 = 0xFF, pixel3 = 0x00 (edge clamp check).
- Reset pulsed mid-row 50 -> all outputs 0 next cycle, then frame restarts at r = 1, waddr = 0; full count 25440 is reached.
- With MEDIAN_BYPASS_EN and bypass = 1 on the impulse image -> output row 100 word 25 pixel1 = 0xFF.
